// File: rtl/cla64_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cla64_addsub_pipe                                            |
// | Description : Two-stage pipelined WIDTH-bit adder/subtractor built from    |
// |               16-bit carry-lookahead slices. Stage 1 forms the bit and     |
// |               slice generate/propagate terms; stage 2 runs a second-level  |
// |               lookahead carry unit over the slice G/P terms, forms the sum |
// |               and registers every output. Valid/ready on both sides.       |
// | Ports       : clk, rst           clock, synchronous active-high reset      |
// |               in_valid/in_ready  operand beat handshake                    |
// |               in_a, in_b         operands (WIDTH bits)                     |
// |               in_sub, in_cin     1 = A - B; carry-in / borrow-in           |
// |               out_valid/out_ready result handshake                         |
// |               out_sum            result, modulo 2^WIDTH                    |
// |               out_cout, out_ovf  carry out of MSB, signed overflow         |
// |               out_gm, out_pm     whole-word generate / propagate           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module cla64_addsub_pipe #(
  parameter int WIDTH = 64,  // multiple of GROUP, 16..128
  parameter int GROUP = 16   // slice width; only 16 is supported
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_gm,
  output logic             out_pm
);

  localparam int N = WIDTH / GROUP;

  // 4-bit lookahead group: returns {G, P}.
  function automatic logic [1:0] cla4_gp(input logic [3:0] g, input logic [3:0] p);
    logic gs;
    gs = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gs, &p};
  endfunction

  // 4-bit lookahead carries: carry into each of the four positions.
  function automatic logic [3:0] cla4_carries(input logic [3:0] g, input logic [3:0] p,
                                              input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // 16-bit slice group generate/propagate, two levels of 4-bit lookahead.
  function automatic logic [1:0] cla16_gp(input logic [15:0] g, input logic [15:0] p);
    logic [3:0] gg;
    logic [3:0] pg;
    logic [1:0] t;
    for (int j = 0; j < 4; j++) begin
      t     = cla4_gp(g[4*j +: 4], p[4*j +: 4]);
      gg[j] = t[1];
      pg[j] = t[0];
    end
    return cla4_gp(gg, pg);
  endfunction

  // Carry into every bit of a 16-bit slice given the slice carry-in.
  function automatic logic [15:0] cla16_carries(input logic [15:0] g, input logic [15:0] p,
                                                input logic cin);
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [3:0]  cg;
    logic [1:0]  t;
    logic [15:0] c;
    for (int j = 0; j < 4; j++) begin
      t     = cla4_gp(g[4*j +: 4], p[4*j +: 4]);
      gg[j] = t[1];
      pg[j] = t[0];
    end
    cg = cla4_carries(gg, pg, cin);
    for (int j = 0; j < 4; j++) begin
      c[4*j +: 4] = cla4_carries(g[4*j +: 4], p[4*j +: 4], cg[j]);
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_load;
  logic s1_load;

  // S2 may take a new beat when it is empty or its result leaves this cycle;
  // S1 drains into S2 under the same condition, so in_ready sees out_ready
  // combinationally and no bubble is inserted on simultaneous accept/retire.
  assign s2_load  = !out_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_load;
  assign s1_load  = in_valid & in_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (in_ready) s1_valid_d = in_valid;
    if (s2_load)  out_valid_d = s1_valid_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: effective operands, bit and slice generate/propagate
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] s1_p_d, s1_p_q;
  logic [WIDTH-1:0] s1_g_d, s1_g_q;
  logic [N-1:0]     s1_sg_d, s1_sg_q;
  logic [N-1:0]     s1_sp_d, s1_sp_q;
  logic             s1_c0_d, s1_c0_q;

  assign b_eff   = in_b ^ {WIDTH{in_sub}};
  assign s1_p_d  = in_a ^ b_eff;
  assign s1_g_d  = in_a & b_eff;
  // Subtraction is A + ~B + 1, so a borrow-in flips the effective carry-in.
  assign s1_c0_d = in_cin ^ in_sub;

  for (genvar k = 0; k < N; k++) begin : g_slice
    logic [1:0] gp;
    assign gp         = cla16_gp(s1_g_d[k*GROUP +: GROUP], s1_p_d[k*GROUP +: GROUP]);
    assign s1_sg_d[k] = gp[1];
    assign s1_sp_d[k] = gp[0];
  end

  // Datapath registers hold their value when not loaded; only valids reset.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_p_q  <= s1_p_d;
      s1_g_q  <= s1_g_d;
      s1_sg_q <= s1_sg_d;
      s1_sp_q <= s1_sp_d;
      s1_c0_q <= s1_c0_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: second-level lookahead carries, sum and flags
  // ---------------------------------------------------------------------------
  logic [N:0]       slc_c;
  logic [WIDTH-1:0] cvec;
  logic [WIDTH-1:0] out_sum_d, out_sum_q;
  logic             out_cout_d, out_cout_q;
  logic             out_ovf_d, out_ovf_q;
  logic             out_gm_d, out_gm_q;
  logic             out_pm_d, out_pm_q;

  // Each slice carry is the flattened lookahead sum-of-products
  // C_{k+1} = OR_j (G_j & P_{j+1..k}) | (P_{0..k} & c0), not a ripple chain.
  always_comb begin
    logic acc;
    logic term;
    logic pall;
    slc_c    = '0;
    slc_c[0] = s1_c0_q;
    for (int k = 0; k < N; k++) begin
      acc  = 1'b0;
      pall = 1'b1;
      for (int j = 0; j <= k; j++) begin
        term = s1_sg_q[j];
        for (int m = j + 1; m <= k; m++) term = term & s1_sp_q[m];
        acc  = acc | term;
        pall = pall & s1_sp_q[j];
      end
      slc_c[k+1] = acc | (pall & s1_c0_q);
    end
  end

  // Whole-word generate: same recurrence with a zero carry-in.
  always_comb begin
    out_gm_d = 1'b0;
    for (int k = 0; k < N; k++) out_gm_d = s1_sg_q[k] | (s1_sp_q[k] & out_gm_d);
  end

  for (genvar k = 0; k < N; k++) begin : g_bitcarry
    assign cvec[k*GROUP +: GROUP] =
      cla16_carries(s1_g_q[k*GROUP +: GROUP], s1_p_q[k*GROUP +: GROUP], slc_c[k]);
  end

  assign out_sum_d  = s1_p_q ^ cvec;
  assign out_cout_d = slc_c[N];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign out_ovf_d  = cvec[WIDTH-1] ^ slc_c[N];
  assign out_pm_d   = &s1_sp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_gm_q    <= 1'b0;
      out_pm_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (s2_load && s1_valid_q) begin
        out_sum_q  <= out_sum_d;
        out_cout_q <= out_cout_d;
        out_ovf_q  <= out_ovf_d;
        out_gm_q   <= out_gm_d;
        out_pm_q   <= out_pm_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_gm    = out_gm_q;
  assign out_pm    = out_pm_q;

endmodule
`default_nettype wire

// File: tb/tb_cla64_addsub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cla64_addsub_pipe                                         |
// | Description : Self-checking bench for cla64_addsub_pipe: directed corner   |
// |               vectors, back-to-back streaming, stalls, reset mid-stall and |
// |               randomized traffic against an arithmetic reference model.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_cla64_addsub_pipe;

  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_gm;
  logic         out_pm;

  int errors = 0;
  int checks = 0;

  cla64_addsub_pipe #(.WIDTH(W), .GROUP(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_gm    (out_gm),
    .out_pm    (out_pm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         gm;
    logic         pm;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic [3:0]   flags;  // {cout, ovf, gm, pm}
  } vec_t;

  // Plain two's-complement arithmetic on a WIDTH+1 bit accumulator.
  function automatic res_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic sub, input logic cin);
    logic [W-1:0] be;
    logic [W:0]   raw;
    logic [W:0]   full;
    res_t         r;
    be     = sub ? ~b : b;
    raw    = {1'b0, a} + {1'b0, be};
    full   = raw + {{W{1'b0}}, cin ^ sub};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
    r.gm   = raw[W];
    r.pm   = &(a ^ be);
    return r;
  endfunction

  function automatic logic [W-1:0] rand64();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
    return v;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_cin   = cin;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    checks++;
    if ({out_sum, out_cout, out_ovf, out_gm, out_pm} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: sum=%h flags=%b%b%b%b want all 0",
               out_sum, out_cout, out_ovf, out_gm, out_pm);
    end
  endtask

  task automatic test_directed();
    vec_t dv[$];
    dv.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 4'b1010});
    dv.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b0100});
    dv.push_back('{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000});
    dv.push_back('{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 4'b1010});
    dv.push_back('{64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0001_0000_0000_0000, 4'b0000});
    dv.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001});
    dv.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0, 4'b1001});
    dv.push_back('{64'h0, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001});
    dv.push_back('{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1110});
    out_ready = 1'b1;
    foreach (dv[i]) begin
      @(posedge clk); #1;
      drive(1'b1, dv[i].a, dv[i].b, dv[i].sub, dv[i].cin);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL dir%0d_early_valid: got %b want 0 one cycle after accept", i, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL dir%0d_latency: out_valid %b want 1 two cycles after accept", i, out_valid);
      end
      checks++;
      if (out_sum !== dv[i].sum) begin
        errors++; $display("FAIL dir%0d_sum: got %h want %h", i, out_sum, dv[i].sum);
      end
      checks++;
      if ({out_cout, out_ovf, out_gm, out_pm} !== dv[i].flags) begin
        errors++;
        $display("FAIL dir%0d_flags(cout,ovf,gm,pm): got %b%b%b%b want %b",
                 i, out_cout, out_ovf, out_gm, out_pm, dv[i].flags);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a[8];
    logic [W-1:0] b[8];
    logic         s[8];
    logic         c[8];
    res_t         e[8];
    for (int i = 0; i < 8; i++) begin
      a[i] = rand64(); b[i] = rand64();
      s[i] = 1'($urandom_range(0, 1)); c[i] = 1'($urandom_range(0, 1));
      e[i] = ref_model(a[i], b[i], s[i], c[i]);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 8) drive(1'b1, a[cyc], b[cyc], s[cyc], c[cyc]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (cyc < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready cyc%0d: got %b want 1", cyc, in_ready);
        end
      end
      if (cyc < 2) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_fill cyc%0d: out_valid %b want 0", cyc, out_valid);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== e[cyc-2].sum ||
            {out_cout, out_ovf, out_gm, out_pm} !==
            {e[cyc-2].cout, e[cyc-2].ovf, e[cyc-2].gm, e[cyc-2].pm}) begin
          errors++;
          $display("FAIL b2b_result%0d: valid=%b sum=%h flags=%b%b%b%b want valid=1 sum=%h flags=%b%b%b%b",
                   cyc - 2, out_valid, out_sum, out_cout, out_ovf, out_gm, out_pm,
                   e[cyc-2].sum, e[cyc-2].cout, e[cyc-2].ovf, e[cyc-2].gm, e[cyc-2].pm);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a[3];
    logic [W-1:0] b[3];
    res_t         e[3];
    for (int i = 0; i < 3; i++) begin
      a[i] = rand64(); b[i] = rand64();
      e[i] = ref_model(a[i], b[i], 1'b0, 1'b0);
    end
    // Four cycles with out_ready low: two beats accepted, then blocked.
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(1'b1, a[cyc < 2 ? cyc : 2], b[cyc < 2 ? cyc : 2], 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (in_ready !== (cyc < 2)) begin
        errors++; $display("FAIL stall_in_ready cyc%0d: got %b want %b", cyc, in_ready, cyc < 2);
      end
      if (cyc >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== e[0].sum || out_cout !== e[0].cout ||
            out_ovf !== e[0].ovf || out_gm !== e[0].gm || out_pm !== e[0].pm) begin
          errors++;
          $display("FAIL stall_hold cyc%0d: valid=%b sum=%h want valid=1 sum=%h stable",
                   cyc, out_valid, out_sum, e[0].sum);
        end
      end
    end
    // Release: the blocked third beat is withdrawn, the two held beats drain.
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_sum !== e[0].sum) begin
      errors++;
      $display("FAIL stall_release0: in_ready=%b valid=%b sum=%h want 1 1 %h",
               in_ready, out_valid, out_sum, e[0].sum);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== e[1].sum || out_cout !== e[1].cout) begin
      errors++;
      $display("FAIL stall_release1: valid=%b sum=%h cout=%b want 1 %h %b",
               out_valid, out_sum, out_cout, e[1].sum, e[1].cout);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drained: out_valid %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midstall();
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      drive(cyc < 2, rand64(), rand64(), 1'b0, 1'b1);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_full: in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
      errors++;
      $display("FAIL rstmid_after: out_valid=%b in_ready=%b sum=%h want 0 1 0",
               out_valid, in_ready, out_sum);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_ghost cyc%0d: out_valid %b want 0", cyc, out_valid);
      end
    end
  endtask

  task automatic test_random();
    res_t         q[$];
    res_t         e;
    logic [W+3:0] snap;
    logic         held;
    int           n_out;
    held  = 1'b0;
    snap  = '0;
    n_out = 0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 400) begin
        drive($urandom_range(0, 9) < 7, rand64(), rand64(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || {out_sum, out_cout, out_ovf, out_gm, out_pm} !== snap) begin
          errors++;
          $display("FAIL rnd_stall_stable cyc%0d: valid=%b sum=%h want held sum=%h",
                   cyc, out_valid, out_sum, snap[W+3:4]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected cyc%0d: result sum=%h with none pending", cyc, out_sum);
        end else begin
          e = q.pop_front();
          n_out++;
          if (out_sum !== e.sum || {out_cout, out_ovf, out_gm, out_pm} !==
              {e.cout, e.ovf, e.gm, e.pm}) begin
            errors++;
            $display("FAIL rnd_result%0d: sum=%h flags=%b%b%b%b want sum=%h flags=%b%b%b%b",
                     n_out, out_sum, out_cout, out_ovf, out_gm, out_pm,
                     e.sum, e.cout, e.ovf, e.gm, e.pm);
          end
        end
      end
      held = out_valid && !out_ready;
      snap = {out_sum, out_cout, out_ovf, out_gm, out_pm};
      if (in_valid && in_ready) q.push_back(ref_model(in_a, in_b, in_sub, in_cin));
    end
    checks++;
    if (q.size() != 0 || n_out < 100) begin
      errors++;
      $display("FAIL rnd_drain: pending=%0d retired=%0d want pending=0 retired>=100", q.size(), n_out);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midstall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
